sr_cmd_driver: RTL and testbench
================================

// Module: sr_cmd_driver
// PURPOSE
//  Initiator/driver side for a bank of SR flip-flops. Accepts masked write
//  requests over a valid/ready handshake and converts them into registered,
//  non-overlapping S/R pulses. Reads Q back after a settle window and reports
//  per-bit mismatch. Sits between control logic and SR storage cells; the
//  S=R=1 forbidden input is never produced.
// PARAMETERS
//  WIDTH          8  number of SR cells driven (>=1)
//  PULSE_CYCLES   2  cycles S/R held active per command (>=1)
//  SETTLE_CYCLES  1  cycles with S=R=0 before readback (>=0)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      async, active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      driver can accept (high only in IDLE)
//  req_data   in   WIDTH  target value per bit
//  req_mask   in   WIDTH  1 = drive this bit, 0 = leave untouched
//  s_out      out  WIDTH  S inputs to SR bank (registered)
//  r_out      out  WIDTH  R inputs to SR bank (registered)
//  q_in       in   WIDTH  Q feedback from SR bank
//  busy       out  1      command in progress (not IDLE)
//  done       out  1      one-cycle pulse: command complete
//  err        out  1      with done: any masked bit mismatched
//  err_bits   out  WIDTH  (q_in ^ data) & mask, held until next done
// BEHAVIOUR
//  Reset (reset=0, immediate): state=IDLE; s_out=r_out=0; req_ready=1 once
//   released; busy=done=err=0; err_bits=0; latched data/mask=0.
//  FSM: IDLE -> PULSE -> SETTLE -> CHECK -> IDLE. SETTLE skipped when
//   SETTLE_CYCLES=0 (PULSE -> CHECK).
//  IDLE: req_ready=1, busy=0, s_out=r_out=0. Accept on edge with
//   req_valid&&req_ready: latch req_data/req_mask, go to PULSE.
//  PULSE: PULSE_CYCLES cycles. Per bit i: s_out[i]=mask[i]&data[i],
//   r_out[i]=mask[i]&~data[i]. Invariant: (s_out & r_out)==0 every cycle.
//  SETTLE: SETTLE_CYCLES cycles, s_out=r_out=0.
//  CHECK: 1 cycle, s_out=r_out=0; at its closing edge sample q_in,
//   err_bits<=(q_in^data)&mask, err<=|that, done<=1, go IDLE.
//  Timing: accept at edge k -> s_out/r_out active after edges k..k+P-1,
//   zero after edge k+P; done=1 for the cycle after edge k+P+S+1
//   (defaults: k+4). req_ready returns high in that same cycle.
//  done: single-cycle pulse. err: valid only with done, 0 otherwise.
//   err_bits: held until next done.
//  Back-to-back: a request may be accepted in the cycle done=1.
//  req_valid while busy: ignored; inputs not sampled; no stall errors.
//  req_mask=0: full sequence runs, outputs stay 0, done=1, err=0.
//  Reset mid-operation: s_out/r_out drop to 0 asynchronously; command
//   discarded; no done issued; IDLE on release.
//  Counter width: enough for max(PULSE_CYCLES,SETTLE_CYCLES); no wrap.
// TESTING
//  1 Reset: reset=0 mid-PULSE -> s_out=r_out=0 same cycle, busy=0, no done.
//  2 Basic: data=8'hA5, mask=8'hFF, q_in follows -> s_out=A5, r_out=5A
//    for 2 cycles; done at k+4, err=0, err_bits=00.
//  3 Masked: data=8'hFF, mask=8'h0F -> s_out=0F, r_out=00; q_in=8'h07
//    -> err=1, err_bits=8'h08.
//  4 Busy: second req_valid during PULSE/SETTLE -> req_ready=0, ignored;
//    one done only; new request accepted in done cycle, runs normally.
//  5 Params: PULSE_CYCLES=1, SETTLE_CYCLES=0 -> pulse 1 cycle, done at k+2.
//  6 Invariant: random data/mask for 1000 commands -> (s_out&r_out)==0
//    always; done count == accept count.

Source files
------------

// File: rtl/sr_cmd_driver.sv
// Masked SR-bank write driver: turns accepted requests into registered,
// non-overlapping S/R pulses, then reads Q back and reports mismatching bits.
module sr_cmd_driver #(
    parameter int WIDTH         = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic [WIDTH-1:0] mask_q, mask_next;
    logic [WIDTH-1:0] s_next, r_next;
    logic [WIDTH-1:0] err_bits_next;
    logic             done_next, err_next;
    logic [WIDTH-1:0] mismatch;

    assign mismatch  = (q_in ^ data_q) & mask_q;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // All outputs are registered, so S and R can never glitch into the forbidden state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            s_out    <= '0;
            r_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_bits <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_q   <= data_next;
            mask_q   <= mask_next;
            s_out    <= s_next;
            r_out    <= r_next;
            done     <= done_next;
            err      <= err_next;
            err_bits <= err_bits_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        data_next     = data_q;
        mask_next     = mask_q;
        s_next        = '0;
        r_next        = '0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        err_bits_next = err_bits;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    data_next  = req_data;
                    mask_next  = req_mask;
                    s_next     = req_mask & req_data;
                    r_next     = req_mask & ~req_data;
                    cnt_next   = '0;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                // Pulse outputs for the next cycle unless this is the last one.
                if (cnt == PULSE_LAST) begin
                    cnt_next   = '0;
                    state_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                    s_next   = mask_q & data_q;
                    r_next   = mask_q & ~data_q;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            CHECK: begin
                done_next     = 1'b1;
                err_bits_next = mismatch;
                err_next      = |mismatch;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized self-checking bench for sr_cmd_driver: default instance plus a
// short-timing instance, checked against a command-level reference model.
module tb_sr_cmd_driver;

    localparam int P  = 2;
    localparam int S  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       req_valid = 1'b0;
    logic [7:0] req_data = '0;
    logic [7:0] req_mask = '0;
    logic       req_ready, busy, done, err;
    logic [7:0] s_out, r_out, q_in, err_bits;

    logic       req_valid2 = 1'b0;
    logic [7:0] req_data2 = '0;
    logic [7:0] req_mask2 = '0;
    logic       req_ready2, busy2, done2, err2;
    logic [7:0] s_out2, r_out2, q_in2, err_bits2;

    logic       q_force = 1'b0;
    logic [7:0] q_val = '0;
    logic [7:0] sr_q = '0;
    logic [7:0] q_val2 = '0;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int accepted = 0;
    logic [7:0] last_err_bits = '0;

    always #5 clk = ~clk;

    // Behavioural SR bank: set wins on S, clear on R, hold otherwise.
    always @(posedge clk) sr_q <= (sr_q & ~r_out) | s_out;
    assign q_in  = q_force ? q_val : sr_q;
    assign q_in2 = q_val2;

    always @(negedge clk) if (done) done_cnt++;

    sr_cmd_driver #(.WIDTH(8), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask), .s_out(s_out), .r_out(r_out),
        .q_in(q_in), .busy(busy), .done(done), .err(err), .err_bits(err_bits)
    );

    sr_cmd_driver #(.WIDTH(8), .PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_data(req_data2), .req_mask(req_mask2), .s_out(s_out2), .r_out(r_out2),
        .q_in(q_in2), .busy(busy2), .done(done2), .err(err2), .err_bits(err_bits2)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("ready_before_req", 32'(req_ready), 32'd1);
    endtask

    // Issues one command from a negedge and follows it through to its done cycle.
    task automatic apply_stimulus(input logic [7:0] d, input logic [7:0] m,
                                  input bit hold_garbage, input bit use_q, input logic [7:0] qv);
        logic [7:0] exp_s, exp_r, exp_eb;
        wait_ready();
        q_force   = use_q;
        q_val     = qv;
        req_valid = 1'b1;
        req_data  = d;
        req_mask  = m;
        @(negedge clk);
        accepted++;
        exp_s  = d & m;
        exp_r  = ~d & m;
        exp_eb = use_q ? ((qv ^ d) & m) : 8'h00;
        for (int c = 0; c < P + S + 1; c++) begin
            check_output("s_out", 32'(s_out), 32'(c < P ? exp_s : 8'h00));
            check_output("r_out", 32'(r_out), 32'(c < P ? exp_r : 8'h00));
            check_output("s_and_r", 32'(s_out & r_out), 32'd0);
            check_output("busy", 32'(busy), 32'd1);
            check_output("ready_busy", 32'(req_ready), 32'd0);
            check_output("done_early", 32'(done), 32'd0);
            check_output("err_idle", 32'(err), 32'd0);
            check_output("err_bits_held", 32'(err_bits), 32'(last_err_bits));
            if (hold_garbage) begin
                req_valid = 1'b1;
                req_data  = 8'($urandom);
                req_mask  = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_output("done", 32'(done), 32'd1);
        check_output("ready_in_done", 32'(req_ready), 32'd1);
        check_output("err", 32'(err), 32'(exp_eb != 8'h00));
        check_output("err_bits", 32'(err_bits), 32'(exp_eb));
        check_output("s_done", 32'(s_out | r_out), 32'd0);
        last_err_bits = exp_eb;
    endtask

    initial begin
        logic [7:0] d, m, qv;
        int snap;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        check_output("rst_s", 32'(s_out), 32'd0);
        check_output("rst_r", 32'(r_out), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_err_bits", 32'(err_bits), 32'd0);
        check_output("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic, masked, empty mask");
        apply_stimulus(8'hA5, 8'hFF, 1'b0, 1'b0, 8'h00);
        apply_stimulus(8'hFF, 8'h0F, 1'b0, 1'b1, 8'h07);
        @(negedge clk);
        check_output("done_single", 32'(done), 32'd0);
        check_output("err_after_done", 32'(err), 32'd0);
        check_output("err_bits_hold", 32'(err_bits), 32'h08);
        apply_stimulus(8'h3C, 8'h00, 1'b0, 1'b1, 8'hFF);

        $display("[TB] busy requests ignored, back-to-back accept");
        apply_stimulus(8'h96, 8'hF0, 1'b1, 1'b0, 8'h00);
        apply_stimulus(8'h69, 8'hFF, 1'b0, 1'b1, 8'h6B);

        $display("[TB] reset mid-pulse");
        wait_ready();
        req_valid = 1'b1;
        req_data  = 8'hC3;
        req_mask  = 8'hFF;
        @(negedge clk);
        check_output("pre_rst_s", 32'(s_out), 32'hC3);
        req_valid = 1'b0;
        snap = done_cnt;
        #2 reset = 1'b0;
        #1;
        check_output("midrst_s", 32'(s_out), 32'd0);
        check_output("midrst_r", 32'(r_out), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        last_err_bits = 8'h00;
        repeat (6) @(negedge clk);
        check_output("no_done_after_rst", 32'(done_cnt), 32'(snap));
        check_output("ready_after_rst", 32'(req_ready), 32'd1);

        $display("[TB] short timing instance");
        for (int i = 0; i < 4; i++) begin
            d  = 8'($urandom);
            m  = 8'($urandom);
            qv = (i % 2 == 0) ? d : 8'($urandom);
            check_output("p1_ready", 32'(req_ready2), 32'd1);
            q_val2     = qv;
            req_valid2 = 1'b1;
            req_data2  = d;
            req_mask2  = m;
            @(negedge clk);
            req_valid2 = 1'b0;
            check_output("p1_s", 32'(s_out2), 32'(d & m));
            check_output("p1_r", 32'(r_out2), 32'(~d & m));
            check_output("p1_done_k1", 32'(done2), 32'd0);
            @(negedge clk);
            check_output("p1_s_off", 32'(s_out2 | r_out2), 32'd0);
            check_output("p1_done_k2", 32'(done2), 32'd0);
            @(negedge clk);
            check_output("p1_done", 32'(done2), 32'd1);
            check_output("p1_err_bits", 32'(err_bits2), 32'((qv ^ d) & m));
            check_output("p1_err", 32'(err2), 32'(((qv ^ d) & m) != 8'h00));
        end

        $display("[TB] random commands");
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            apply_stimulus(d, m, 1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                check_output("gap_done", 32'(done), 32'd0);
                check_output("gap_err", 32'(err), 32'd0);
                check_output("gap_err_bits", 32'(err_bits), 32'(last_err_bits));
                check_output("gap_busy", 32'(busy), 32'd0);
                check_output("gap_s", 32'(s_out | r_out), 32'd0);
            end
        end
        @(negedge clk);
        check_output("done_vs_accept", 32'(done_cnt), 32'(accepted));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
